// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared bus widths and arbiter state encoding
package sram_arb_pkg;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 17;
    typedef enum logic [1:0] {IDLE, RD, WR, TURN} arb_state_t;
endpackage

// File: rtl/sram_rd_tag_pipe.sv
// sram_rd_tag_pipe: shift register marking which SRAM returns belong to acked reads
module sram_rd_tag_pipe #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic tag_in,
    output logic tag_out
);
    logic [DEPTH-1:0] tags;
    always_ff @(posedge clk or posedge rst)
        if (rst) tags <= '0;
        else tags <= (tags << 1) | DEPTH'(tag_in);
    assign tag_out = tags[DEPTH-1];
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: read-priority SRAM port arbiter with bounded write wait and write-to-read turnaround
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 4,
    parameter int TURN_CYCLES  = 1,
    parameter int WR_MAX_WAIT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam int WW = $clog2(WR_MAX_WAIT + 2);
    localparam int TW = $clog2(TURN_CYCLES + 2);
    localparam logic [WW-1:0] WAIT_MAX = WW'(WR_MAX_WAIT);
    localparam logic [TW-1:0] TURN_MAX = TW'(TURN_CYCLES);

    arb_state_t    state, state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] turn_cnt;
    logic          wr_win, in_gap;

    // turn_cnt counts idle cycles already presented since the last write, so a read
    // becomes legal once TURN_CYCLES of them have gone out on the bus
    assign wr_win    = wr_req && (!rd_req || wait_cnt >= WAIT_MAX);
    assign in_gap    = TURN_CYCLES > 0 && (state == WR || (state == TURN && turn_cnt < TURN_MAX));
    assign wr_ack    = !rst && wr_win;
    assign rd_ack    = !rst && rd_req && !wr_win && !in_gap;
    assign state_nxt = wr_ack ? WR : rd_ack ? RD : in_gap ? TURN : IDLE;
    assign rd_data   = mem_data_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            turn_cnt    <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_data_in <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (wr_req && !wr_ack) ? (wait_cnt >= WAIT_MAX ? wait_cnt : wait_cnt + 1'b1) : '0;
            turn_cnt <= state_nxt != TURN ? '0 : state == TURN ? turn_cnt + 1'b1 : TW'(1);
            mem_we   <= wr_ack;
            if (wr_ack) begin
                mem_addr    <= wr_addr;
                mem_data_in <= wr_data;
            end else if (rd_ack) begin
                mem_addr <= rd_addr;
            end
        end
    end

    sram_rd_tag_pipe #(.DEPTH(READ_LATENCY + 1)) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (rd_ack),
        .tag_out(rd_valid)
    );
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed scoreboard bench for sram_arbiter against a cycle-rule model
module tb_sram_arbiter;
    localparam int READ_LATENCY = 4;
    localparam int TURN_CYCLES  = 1;
    localparam int WR_MAX_WAIT  = 8;

    typedef struct {int due; int addr; int data;} exp_t;
    typedef struct {int addr; int data;} wr_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        rd_req = 1'b0, wr_req = 1'b0, rd_ack, wr_ack, rd_valid, mem_we;
    logic [19:0] rd_addr = '0, wr_addr = '0, mem_addr;
    logic [16:0] wr_data = '0, rd_data, mem_data_in, mem_data_out;

    logic        rd_req1 = 1'b0, wr_req1 = 1'b0, rd_ack1, wr_ack1, rd_valid1, mem_we1;
    logic [19:0] rd_addr1 = '0, wr_addr1 = '0, mem_addr1;
    logic [16:0] wr_data1 = '0, rd_data1, mem_data_in1;
    logic [16:0] mem_data_out1 = '0;

    int   n_pass = 0, n_total = 0, cyc = 0, n_valid = 0, wr_raise = 0;
    int   ref_mem [256];
    exp_t rd_q[$], wq[$];
    int   rd_stim[$], rd_log[$], wr_log[$], we_log[$];
    wr_t  wr_stim[$];

    sram_arbiter #(.READ_LATENCY(READ_LATENCY), .TURN_CYCLES(TURN_CYCLES), .WR_MAX_WAIT(WR_MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .rd_valid(rd_valid), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    sram_arbiter #(.READ_LATENCY(READ_LATENCY), .TURN_CYCLES(0), .WR_MAX_WAIT(WR_MAX_WAIT)) dut_t0 (
        .clk(clk), .rst(rst), .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_ack(rd_ack1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_ack(wr_ack1),
        .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] init_val(input int a);
        return 17'(a * 613 + 99);
    endfunction

    // pipelined SRAM: data for an address sampled at an edge appears READ_LATENCY cycles later
    logic [16:0] sram [256];
    logic [16:0] rpipe [READ_LATENCY];
    bit          sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
            sram_init <= 1'b1;
        end else if (mem_we) begin
            sram[mem_addr[7:0]] <= mem_data_in;
        end
        rpipe[0] <= sram[mem_addr[7:0]];
        for (int i = 1; i < READ_LATENCY; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_data_out = rpipe[READ_LATENCY-1];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: arbitration rules, read return timing/data and write issue
    initial begin
        int  pend, last_wr;
        bit  exp_wr, exp_rd;
        exp_t e;
        pend = 0;
        last_wr = -100;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_rd_ack", rd_ack, 0);
                chk("rst_wr_ack", wr_ack, 0);
                chk("rst_rd_valid", rd_valid, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_data_in", mem_data_in, 0);
                rd_q.delete();
                wq.delete();
                pend = 0;
                last_wr = -100;
            end else begin
                if (rd_valid) begin
                    if (rd_q.size() == 0) chk("rd_valid_spurious", rd_valid, 0);
                    else begin
                        e = rd_q.pop_front();
                        chk("rd_valid_cycle", cyc, e.due);
                        chk("rd_data", rd_data, e.data);
                        n_valid++;
                    end
                end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
                    e = rd_q.pop_front();
                    chk("rd_valid_missing", rd_valid, 1);
                end
                if (mem_we) begin
                    if (wq.size() == 0) chk("wr_issue_spurious", mem_we, 0);
                    else begin
                        e = wq.pop_front();
                        chk("wr_issue_cycle", cyc, e.due);
                        chk("wr_issue_addr", mem_addr, e.addr);
                        chk("wr_issue_data", mem_data_in, e.data);
                    end
                    we_log.push_back(cyc);
                end else if (wq.size() != 0 && wq[0].due <= cyc) begin
                    e = wq.pop_front();
                    chk("wr_issue_missing", mem_we, 1);
                end
                exp_wr = wr_req && (!rd_req || pend >= WR_MAX_WAIT);
                exp_rd = rd_req && !exp_wr && (cyc - last_wr > TURN_CYCLES);
                chk("wr_ack", wr_ack, exp_wr);
                chk("rd_ack", rd_ack, exp_rd);
                if (rd_ack) begin
                    rd_q.push_back('{due: cyc + READ_LATENCY + 1, addr: int'(rd_addr), data: ref_mem[rd_addr[7:0]]});
                    rd_log.push_back(cyc);
                end
                if (wr_ack) begin
                    ref_mem[wr_addr[7:0]] = int'(wr_data);
                    wq.push_back('{due: cyc + 1, addr: int'(wr_addr), data: int'(wr_data)});
                    wr_log.push_back(cyc);
                    last_wr = cyc;
                end
                pend = (wr_req && !wr_ack) ? pend + 1 : 0;
            end
        end
    end

    // requesters: each holds its request until acked, then takes the next queued item
    initial begin
        bit acked;
        forever begin
            @(negedge clk);
            acked = rd_req && rd_ack;
            @(posedge clk);
            #1;
            if (acked || !rd_req) begin
                if (rd_stim.size() != 0) begin
                    rd_addr = 20'(rd_stim.pop_front());
                    rd_req = 1'b1;
                end else rd_req = 1'b0;
            end
        end
    end

    initial begin
        bit  acked;
        wr_t w;
        forever begin
            @(negedge clk);
            acked = wr_req && wr_ack;
            @(posedge clk);
            #1;
            if (acked || !wr_req) begin
                if (wr_stim.size() != 0) begin
                    w = wr_stim.pop_front();
                    wr_addr = 20'(w.addr);
                    wr_data = 17'(w.data);
                    if (!wr_req) wr_raise = cyc;
                    wr_req = 1'b1;
                end else wr_req = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(rd_stim.size() == 0 && wr_stim.size() == 0 && !rd_req && !wr_req && rd_q.size() == 0 && wq.size() == 0)) begin
            @(posedge clk);
            #2;
            n++;
            if (n > 300) begin
                chk("idle_timeout", n, 300);
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0, n, c, nxt;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // streaming reads of 0..7
        for (int i = 0; i < 8; i++) rd_stim.push_back(i);
        rd_log.delete();
        v0 = n_valid;
        wait_idle();
        chk("p1_rd_acks", rd_log.size(), 8);
        if (rd_log.size() == 8) chk("p1_rd_contiguous", rd_log[7] - rd_log[0], 7);
        chk("p1_valids", n_valid - v0, 8);

        // write-only burst
        wr_log.delete();
        we_log.delete();
        v0 = n_valid;
        for (int i = 0; i < 4; i++) wr_stim.push_back('{addr: 'h10 + i, data: int'($urandom_range(0, 131071))});
        wait_idle();
        chk("p2_wr_acks", wr_log.size(), 4);
        chk("p2_we_cycles", we_log.size(), 4);
        if (wr_log.size() == 4 && we_log.size() == 4) begin
            chk("p2_wr_contiguous", wr_log[3] - wr_log[0], 3);
            chk("p2_we_contiguous", we_log[3] - we_log[0], 3);
            chk("p2_we_start", we_log[0], wr_log[0] + 1);
        end
        chk("p2_no_valid", n_valid - v0, 0);

        // write starved by a read stream until the wait bound
        rd_log.delete();
        wr_log.delete();
        for (int i = 0; i < 30; i++) rd_stim.push_back(i % 16);
        repeat (10) @(posedge clk);
        #2 wr_stim.push_back('{addr: 20, data: 'h1234});
        wait_idle();
        chk("p3_wr_acks", wr_log.size(), 1);
        if (wr_log.size() == 1) begin
            chk("p3_wr_wait", wr_log[0] - wr_raise, WR_MAX_WAIT);
            nxt = -1;
            foreach (rd_log[i]) if (nxt < 0 && rd_log[i] > wr_log[0]) nxt = rd_log[i];
            chk("p3_rd_after_turn", nxt, wr_log[0] + 2);
        end

        // write then read requested the following cycle
        rd_log.delete();
        we_log.delete();
        wr_stim.push_back('{addr: 30, data: 'h0beef});
        n = 0;
        c = -1;
        while (c < 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (wr_ack) c = cyc;
        end
        chk("p4_wr_seen", c >= 0, 1);
        rd_stim.push_back(30);
        wait_idle();
        chk("p4_rd_acks", rd_log.size(), 1);
        if (rd_log.size() == 1) chk("p4_rd_ack_cycle", rd_log[0], c + 2);
        chk("p4_we_cycles", we_log.size(), 1);
        if (we_log.size() == 1) chk("p4_we_cycle", we_log[0], c + 1);

        // same sequence without turnaround
        @(posedge clk);
        #1;
        wr_addr1 = 20'd5;
        wr_data1 = 17'h1abc;
        wr_req1 = 1'b1;
        @(negedge clk);
        chk("t0_wr_ack", wr_ack1, 1);
        @(posedge clk);
        #1;
        wr_req1 = 1'b0;
        rd_addr1 = 20'd6;
        rd_req1 = 1'b1;
        @(negedge clk);
        chk("t0_rd_ack", rd_ack1, 1);
        chk("t0_wr_we", mem_we1, 1);
        chk("t0_wr_addr", mem_addr1, 5);
        chk("t0_wr_data", mem_data_in1, 'h1abc);
        @(posedge clk);
        #1 rd_req1 = 1'b0;
        @(negedge clk);
        chk("t0_rd_we", mem_we1, 0);
        chk("t0_rd_addr", mem_addr1, 6);
        repeat (3) @(negedge clk);
        chk("t0_valid_early", rd_valid1, 0);
        @(negedge clk);
        chk("t0_valid", rd_valid1, 1);

        // reset with reads in flight
        wait_idle();
        rd_log.delete();
        for (int i = 0; i < 3; i++) rd_stim.push_back(40 + i);
        n = 0;
        while (rd_log.size() < 3 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("p5_rd_acks", rd_log.size(), 3);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        v0 = n_valid;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("p5_no_valid", rd_valid, 0);
        end
        chk("p5_valid_count", n_valid - v0, 0);

        // simultaneous requests from idle
        wait_idle();
        rd_log.delete();
        wr_log.delete();
        rd_stim.push_back(50);
        wr_stim.push_back('{addr: 51, data: 'h777});
        wait_idle();
        chk("p6_acks", rd_log.size() + wr_log.size(), 2);
        if (rd_log.size() == 1 && wr_log.size() == 1) chk("p6_rd_first", wr_log[0] - rd_log[0], 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (rd_stim.size() < 3 && $urandom_range(0, 99) < 55) rd_stim.push_back(int'($urandom_range(0, 15)));
            if (wr_stim.size() < 3 && $urandom_range(0, 99) < 35)
                wr_stim.push_back('{addr: int'($urandom_range(0, 15)), data: int'($urandom_range(0, 131071))});
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
